// File: rtl/pe_dc_sched.sv
// Purpose: sequences one combinational decoder PE over every output channel and pooled pixel.
// Latency: 1 cycle from start to cfg_req; 2 cycles per pixel; +1 (+ack wait) per channel switch.
// Backpressure: stalls in CFG on cfg_ack, in WAIT_WIN on win_valid, and in EMIT on out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start / busy / done   layer pass control and status (done is a 1-cycle pulse)
//   cfg_req / cfg_ack     per-channel weight + norm_ref request handshake, ch_idx selects channel
//   pix_idx               current pooled pixel, row-major
//   win_valid / win_ready input window handshake; pidx_in is the pool index for that window
//   pe_in_en / pe_pindex  PE enable and pool index, live only while waiting for a window
//   pe_data_out           combinational PE result, captured when the window is consumed
//   out_valid / out_ready output handshake for out_data and out_addr = {ch_idx, pix_idx}
//
// Optional feature macro: PE_DC_SCHED_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module pe_dc_sched #(
  parameter int IMG_H    = 8,
  parameter int IMG_W    = 8,
  parameter int N_OUT_CH = 64,
  parameter int POOL_H   = 2,
  parameter int POOL_W   = 2,
  localparam int N_PIX   = IMG_H * IMG_W,
  localparam int N_POOL  = POOL_H * POOL_W,
  localparam int PIX_W   = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  localparam int CH_W    = (N_OUT_CH > 1) ? $clog2(N_OUT_CH) : 1,
  localparam int PIDX_W  = (N_POOL > 1) ? $clog2(N_POOL) : 1,
  localparam int OUT_W   = N_POOL,
  localparam int ADDR_W  = CH_W + PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cfg_req,
  input  logic              cfg_ack,
  output logic [CH_W-1:0]   ch_idx,
  output logic [PIX_W-1:0]  pix_idx,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [PIDX_W-1:0] pidx_in,
  output logic              pe_in_en,
  output logic [PIDX_W-1:0] pe_pindex,
  input  logic [OUT_W-1:0]  pe_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef PE_DC_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Exact terminal values so non-power-of-2 sizes never run past the last index.
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_OUT_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT_WIN,
    S_EMIT,
    S_FIN
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_req;
  logic                r_out_valid;
  logic [CH_W-1:0]     r_ch;
  logic [PIX_W-1:0]    r_pix;
  logic [OUT_W-1:0]    r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;

  logic                w_in_win;

  // The PE is combinational, so enable/index must follow win_valid in the same cycle
  // the result is captured; outside WAIT_WIN they are forced low to stop PE toggling.
  assign w_in_win  = (r_state == S_WAIT_WIN);
  assign pe_in_en  = w_in_win & win_valid;
  assign win_ready = w_in_win & win_valid;
  assign pe_pindex = w_in_win ? pidx_in : '0;

  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_req   = r_cfg_req;
  assign ch_idx    = r_ch;
  assign pix_idx   = r_pix;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_ch        <= '0;
      r_pix       <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ch      <= '0;
            r_pix     <= '0;
            r_busy    <= 1'b1;
            r_cfg_req <= 1'b1;
            r_state   <= S_CFG;
          end
        end
        S_CFG: begin
          if (cfg_ack) begin
            r_cfg_req <= 1'b0;
            r_state   <= S_WAIT_WIN;
          end
        end
        S_WAIT_WIN: begin
          if (win_valid) begin
            r_out_data  <= pe_data_out;
            r_out_addr  <= {r_ch, r_pix};
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_pix == PIX_LAST) begin
              r_pix <= '0;
              if (r_ch == CH_LAST) begin
                // done is raised on entry so it is visible for exactly the FIN cycle.
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_ch      <= r_ch + 1'b1;
                r_cfg_req <= 1'b1;
                r_state   <= S_CFG;
              end
            end else begin
              r_pix   <= r_pix + 1'b1;
              r_state <= S_WAIT_WIN;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_DC_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == S_CFG)      && !cfg_ack)   ||
                   ((r_state == S_WAIT_WIN) && !win_valid) ||
                   ((r_state == S_EMIT)     && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_dc_sched.sv
module tb_pe_dc_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cfg_ack = 1'b0;
  logic       win_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] pidx_in;
  logic [3:0] pe_data_out;
  logic       busy, done, cfg_req, win_ready, pe_in_en, out_valid;
  logic [0:0] ch_idx;
  logic [1:0] pix_idx, pe_pindex;
  logic [3:0] out_data;
  logic [2:0] out_addr;
`ifdef PE_DC_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [6:0] sb[$];            // {addr[2:0], data[3:0]}
  logic [2:0] win_cnt;
  logic [1:0] pidx_tab [8] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2};

  pe_dc_sched #(.IMG_H(2), .IMG_W(2), .N_OUT_CH(2), .POOL_H(2), .POOL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .ch_idx(ch_idx), .pix_idx(pix_idx),
    .win_valid(win_valid), .win_ready(win_ready), .pidx_in(pidx_in),
    .pe_in_en(pe_in_en), .pe_pindex(pe_pindex), .pe_data_out(pe_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
`ifdef PE_DC_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Index buffer: one pool index per consumed window, in pixel order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_cnt <= 3'd0;
    else if (win_valid && win_ready) win_cnt <= win_cnt + 3'd1;
  end
  assign pidx_in = pidx_tab[win_cnt];

  // PE model: unpooling demux of a '1' result; all-ones when disabled so a held
  // out_data is distinguishable from the live PE output.
  assign pe_data_out = pe_in_en ? (4'b0001 << pe_pindex) : 4'b1111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic load_pass();
    logic [2:0] a;
    logic [3:0] d;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    for (int k = 0; k < 8; k++) begin
      a = 3'(k);
      d = 4'b0001 << pidx_tab[k];
      sb.push_back({a, d});
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) break;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  // Monitor: compares every accepted output against the scoreboard.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_out: got addr %0h data %0h, expected no output", out_addr, out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_addr", 32'(out_addr), 32'(e[6:4]));
          chk("sb_data", 32'(out_data), 32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    int c;
    int d0;
    bit found;

    // Reset with random inputs
    repeat (4) begin
      step();
      start     = 1'($urandom_range(0, 1));
      cfg_ack   = 1'($urandom_range(0, 1));
      win_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_req", 32'(cfg_req), 32'd0);
    chk("rst_win_ready", 32'(win_ready), 32'd0);
    chk("rst_pe_in_en", 32'(pe_in_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'({ch_idx, pix_idx, pe_pindex}), 32'd0);
    chk("rst_out", 32'({out_data, out_addr}), 32'd0);
    start = 0; cfg_ack = 0; win_valid = 0; out_ready = 0;
    rst_n = 1'b1;
    step();

    // Basic pass, all handshakes high: done in cycle 20 counting the start cycle as 1
    load_pass();
    cfg_ack = 1; win_valid = 1; out_ready = 1; start = 1;
    d0 = done_cnt;
    c = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      c++;
      start = 0;
      if (c == 2) begin
        chk("start_to_cfg_req", 32'(cfg_req), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
      end
      if (done) break;
    end
    chk("done_cycle", 32'(c), 32'd20);
    step();
    chk("busy_clear", 32'(busy), 32'd0);
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    chk("basic_all_out", 32'(sb.size()), 32'd0);

    // Backpressure: out_ready low for 5 EMIT cycles holding 4'b0100
    load_pass();
    out_ready = 0; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      step();
    end
    chk("bp_reach_emit", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'b0100);
      chk("bp_pix_idx", 32'(pix_idx), 32'd0);
      chk("bp_pe_in_en", 32'(pe_in_en), 32'd0);
      chk("bp_win_ready", 32'(win_ready), 32'd0);
      step();
    end
    out_ready = 1;
    wait_done("bp_done", 100);
    step();

    // Window starvation: win_valid low for 3 WAIT_WIN cycles
    load_pass();
    win_valid = 0; start = 1;
    step();            // CFG
    start = 0;
    step();            // WAIT_WIN
`ifdef PE_DC_SCHED_STALL_CNT_EN
    chk("stall_clr_on_start", stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      chk("starve_pe_in_en", 32'(pe_in_en), 32'd0);
      chk("starve_win_ready", 32'(win_ready), 32'd0);
      step();
    end
    win_valid = 1;
`ifdef PE_DC_SCHED_STALL_CNT_EN
    chk("stall_cnt_3", stall_cnt, 32'd3);
`endif
    wait_done("starve_done", 100);
`ifdef PE_DC_SCHED_STALL_CNT_EN
    chk("stall_cnt_final", stall_cnt, 32'd3);
`endif
    step();

    // Mid-pass reset during the ch 1 pix 2 EMIT
    load_pass();
    start = 1;
    step();
    start = 0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && out_addr == 3'd6) begin
        found = 1;
        break;
      end
      step();
    end
    chk("mr_reach_ch1_pix2", 32'(found), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_cfg_req", 32'(cfg_req), 32'd0);
    chk("mr_idx", 32'({ch_idx, pix_idx}), 32'd0);
    chk("mr_out", 32'({out_data, out_addr}), 32'd0);
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
    load_pass();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      step();
    end
    chk("mr_restart_addr", 32'(out_addr), 32'd0);
    chk("mr_restart_ch", 32'(ch_idx), 32'd0);
    wait_done("mr_done", 100);
    step();
    chk("mr_one_done", 32'(done_cnt - d0), 32'd1);

    // start while busy at pix 3
    load_pass();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 50; i++) begin
      if (pix_idx == 2'd3) break;
      step();
    end
    chk("sb_reach_pix3", 32'(pix_idx), 32'd3);
    d0 = done_cnt;
    start = 1;
    step();
    start = 0;
    chk("sb_busy_ch", 32'(ch_idx), 32'd0);
    chk("sb_busy_pix", 32'(pix_idx), 32'd3);
    chk("sb_busy_busy", 32'(busy), 32'd1);
    wait_done("sbusy_done", 100);
    repeat (6) step();
    chk("sbusy_single_done", 32'(done_cnt - d0), 32'd1);
    chk("sbusy_idle", 32'(busy), 32'd0);
    chk("sbusy_all_out", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
